// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C master + LIFO slave subsystem.
//   master_state_t : master FSM states (visible on the debug bus)
//   slave_state_t  : LIFO slave protocol tracker states (visible on the debug bus)
//   LIFO_ADDR_DEF  : default 7-bit slave address (0x79 -> 0xF2 write, 0xF3 read)
//   BIT_CYCLES     : clk cycles per SCL bit (one low phase, one high phase)
//   RW_READ/RW_WRITE : meaning of the R/W bit in the address byte
package i2c_pkg;

  localparam logic [6:0] LIFO_ADDR_DEF = 7'h79;
  localparam int         BIT_CYCLES    = 2;
  localparam logic       RW_READ       = 1'b1;
  localparam logic       RW_WRITE      = 1'b0;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP
  } master_state_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT
  } slave_state_t;

  // Value of the in-state cycle counter on the final cycle of each master state.
  function automatic logic [3:0] state_last(master_state_t s);
    case (s)
      ADDR, WRITE, READ: return 4'(8 * BIT_CYCLES - 1);
      default:           return 4'(BIT_CYCLES - 1);
    endcase
  endfunction

endpackage

// File: rtl/i2c_wrapper_if.sv
// i2c_wrapper_if: command/result bus of the I2C subsystem plus debug taps.
//   start           : one-cycle pulse launching a transaction (driver -> design)
//   Data            : address byte with start, write byte at the latch point
//   received_data   : last byte returned by a successful read
//   dbg_*           : master state, slave state, SCL, resolved SDA, LIFO pointer
// Handshake: start is a single-cycle request with no ready; the design takes
// it only when dbg_state is IDLE and silently drops it otherwise.
// Modports: slave = the design side, master = the driving side.
interface i2c_wrapper_if #(parameter int PTR_W = 4);
  import i2c_pkg::*;

  logic             start;
  logic [7:0]       Data;
  logic [7:0]       received_data;
  master_state_t    dbg_state;
  slave_state_t     dbg_slave_state;
  logic             dbg_scl;
  logic             dbg_sda;
  logic [PTR_W-1:0] dbg_ptr;

  modport slave (
    input  start, Data,
    output received_data, dbg_state, dbg_slave_state, dbg_scl, dbg_sda, dbg_ptr
  );

  modport master (
    output start, Data,
    input  received_data, dbg_state, dbg_slave_state, dbg_scl, dbg_sda, dbg_ptr
  );

endinterface

// File: rtl/i2c_wrapper_lifo_slave.sv
// lifo_slave: I2C slave that stores written bytes in a LIFO and returns the
// top entry on reads. Watches SCL/SDA for START/STOP, samples SDA at each SCL
// high phase, and pulls SDA low through sda_oe (open drain).
//   clk, rst : clock, asynchronous active-low reset (pointer cleared)
//   scl, sda : resolved bus lines
//   sda_oe   : 1 = pull SDA low
//   ptr      : number of stored entries (0..LIFO_DEPTH)
//   state    : protocol tracker state (debug)
// Macro LIFO_PEEK_EN: when defined, reads leave the pointer unchanged.
module lifo_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] LIFO_ADDR  = LIFO_ADDR_DEF,
  parameter int         LIFO_DEPTH = 8,
  parameter int         DATA_W     = 8,
  parameter int         PTR_W      = $clog2(LIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl,
  input  logic             sda,
  output logic             sda_oe,
  output logic [PTR_W-1:0] ptr,
  output slave_state_t     state
);

  localparam int AW = $clog2(LIFO_DEPTH);

  slave_state_t      state_d;
  logic              scl_q, sda_q;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-2:0] tx;
  logic              rw;
  logic [DATA_W-1:0] mem [LIFO_DEPTH];

  logic              start_det, stop_det, h_end, full, push;
  logic [DATA_W-1:0] byte_in, top;
  logic [PTR_W-1:0]  ptr_m1;

  // START/STOP need SCL high on both samples so that a simultaneous SCL/SDA
  // change at a phase boundary is never mistaken for a bus condition.
  assign start_det = scl && scl_q && sda_q && !sda;
  assign stop_det  = scl && scl_q && !sda_q && sda;
  // Rising SCL seen now: the cycle just ending was a high (sample) phase and
  // the next one is the low phase of the following bit.
  assign h_end     = scl && !scl_q;
  assign byte_in   = {sh[DATA_W-2:0], sda};
  assign full      = (ptr == PTR_W'(LIFO_DEPTH));
  assign ptr_m1    = ptr - 1'b1;
  assign top       = (ptr != '0) ? mem[ptr_m1[AW-1:0]] : '0;
  assign push      = h_end && !start_det && !stop_det && (state == S_WRITE_ACK) && !full;

  always_comb begin
    state_d = state;
    if (start_det) begin
      state_d = S_ADDR;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else if (h_end) begin
      case (state)
        S_ADDR:      if (bit_cnt == 3'd7)
                       state_d = (byte_in[7:1] == LIFO_ADDR) ? S_ADDR_ACK : S_WAIT;
        S_ADDR_ACK:  state_d = (rw == RW_READ) ? S_READ : S_WRITE;
        S_WRITE:     if (bit_cnt == 3'd7) state_d = S_WRITE_ACK;
        S_WRITE_ACK: state_d = S_WAIT;
        S_READ:      if (bit_cnt == 3'd7) state_d = S_READ_ACK;
        S_READ_ACK:  state_d = S_WAIT;
        default:     state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      sda_oe  <= 1'b0;
      bit_cnt <= '0;
      sh      <= '0;
      tx      <= '0;
      rw      <= RW_WRITE;
      ptr     <= '0;
    end else begin
      state <= state_d;
      scl_q <= scl;
      sda_q <= sda;
      if (start_det || stop_det) begin
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (h_end) begin
        bit_cnt <= bit_cnt + 3'd1;
        sh      <= byte_in;
        case (state)
          S_ADDR: if (bit_cnt == 3'd7) begin
            rw     <= byte_in[0];
            sda_oe <= (byte_in[7:1] == LIFO_ADDR);
          end
          S_ADDR_ACK: begin
            bit_cnt <= '0;
            if (rw == RW_READ) begin
              // Empty LIFO reads as 0x00 (top is forced to zero).
              tx     <= top[DATA_W-2:0];
              sda_oe <= ~top[DATA_W-1];
            end else begin
              sda_oe <= 1'b0;
            end
          end
          S_WRITE: if (bit_cnt == 3'd7) sda_oe <= !full;
          S_WRITE_ACK: begin
            sda_oe <= 1'b0;
            if (!full) ptr <= ptr + 1'b1;
          end
          S_READ: begin
            if (bit_cnt == 3'd7) begin
              sda_oe <= 1'b0;
`ifdef LIFO_PEEK_EN
              ptr <= ptr;
`else
              if (ptr != '0) ptr <= ptr_m1;
`endif
            end else begin
              sda_oe <= ~tx[DATA_W-2];
              tx     <= {tx[DATA_W-3:0], 1'b0};
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

  // Storage has no reset: a cleared pointer makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[ptr[AW-1:0]] <= sh;
  end

endmodule

// File: rtl/i2c_wrapper.sv
// i2c_wrapper: I2C master FSM and a LIFO slave on internal SCL/SDA nets.
// SDA is a wired-AND of the master's drive and the slave's pull-down.
// A start pulse with an address byte on Data runs one 40-cycle transaction:
// writes push the Data byte present at the latch point, reads pop the top
// entry into received_data at STOP.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : i2c_wrapper_if.slave (start, Data, received_data, debug taps)
// Macro LIFO_PEEK_EN (in lifo_slave): reads return the top entry without popping.
module i2c_wrapper
  import i2c_pkg::*;
#(
  parameter logic [6:0] LIFO_ADDR  = LIFO_ADDR_DEF,
  parameter int         LIFO_DEPTH = 8,
  parameter int         DATA_W     = 8
) (
  input  logic          clk,
  input  logic          rst,
  i2c_wrapper_if.slave  bus
);

  localparam int PTR_W = $clog2(LIFO_DEPTH + 1);

  master_state_t     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, tx_q, rx_q, recv_q;
  logic              rd_ok_q;
  logic              scl, sda_m, sda, slave_oe;
  logic [PTR_W-1:0]  ptr;
  slave_state_t      slave_state;

  assign sda = sda_m & ~slave_oe;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    if (cnt_q == state_last(state_q)) begin
      case (state_q)
        START:     state_d = ADDR;
        ADDR:      state_d = ADDR_ACK;
        ADDR_ACK:  state_d = sda ? STOP : ((addr_q[0] == RW_READ) ? READ : WRITE);
        WRITE:     state_d = WRITE_ACK;
        WRITE_ACK: state_d = STOP;
        READ:      state_d = READ_NACK;
        READ_NACK: state_d = STOP;
        STOP:      state_d = IDLE;
        default:   state_d = state_q;
      endcase
    end
    if (state_q == IDLE) state_d = bus.start ? START : IDLE;
    if (state_d != state_q || state_q == IDLE) cnt_d = '0;
  end

  // Bus drive: even counter values are the SCL-low phase, odd are SCL-high.
  always_comb begin
    scl   = 1'b1;
    sda_m = 1'b1;
    case (state_q)
      IDLE:  scl = 1'b1;
      START: sda_m = 1'b0;
      ADDR: begin
        scl   = cnt_q[0];
        sda_m = addr_q[3'd7 - cnt_q[3:1]];
      end
      WRITE: begin
        scl   = cnt_q[0];
        sda_m = tx_q[3'd7 - cnt_q[3:1]];
      end
      // Hold SDA low through STOP; it is released on return to IDLE, which
      // gives the SDA rise with SCL high.
      STOP: begin
        scl   = cnt_q[0];
        sda_m = 1'b0;
      end
      default: scl = cnt_q[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_ok_q <= 1'b0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.start) addr_q <= bus.Data;
      if (state_q == ADDR_ACK && state_d == WRITE) tx_q <= bus.Data;
      if (state_q == READ && cnt_q[0]) rx_q <= {rx_q[DATA_W-2:0], sda};
      if (state_q == ADDR_ACK && cnt_q[0]) rd_ok_q <= !sda && (addr_q[0] == RW_READ);
      if (state_q == STOP && cnt_q[0] && rd_ok_q) recv_q <= rx_q;
    end
  end

  lifo_slave #(
    .LIFO_ADDR  (LIFO_ADDR),
    .LIFO_DEPTH (LIFO_DEPTH),
    .DATA_W     (DATA_W),
    .PTR_W      (PTR_W)
  ) u_slave (
    .clk    (clk),
    .rst    (rst),
    .scl    (scl),
    .sda    (sda),
    .sda_oe (slave_oe),
    .ptr    (ptr),
    .state  (slave_state)
  );

  assign bus.received_data   = recv_q;
  assign bus.dbg_state       = state_q;
  assign bus.dbg_slave_state = slave_state;
  assign bus.dbg_scl         = scl;
  assign bus.dbg_sda         = sda;
  assign bus.dbg_ptr         = ptr;

endmodule

// File: tb/tb_i2c_wrapper.sv
// tb_i2c_wrapper: drives transactions into i2c_wrapper and checks the bus
// bits, ACK/NACK, LIFO pointer and received_data against a queue-based LIFO
// model of the subsystem.
module tb_i2c_wrapper;
  import i2c_pkg::*;

  logic clk;
  logic rst;
  i2c_wrapper_if iface ();

  i2c_wrapper dut (
    .clk (clk),
    .rst (rst),
    .bus (iface)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] lifo_q [$];   // model LIFO contents, top = last element
  logic [7:0] exp_q  [$];   // expected results of pending reads
  logic [7:0] exp_recv;
  bit         chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // received_data must equal the model value on every cycle out of reset.
  always @(negedge clk) begin
    if (rst && chk_en) begin
      n_cmp++;
      if (iface.received_data !== exp_recv) begin
        n_bad++;
        $display("FAIL recv_cycle: got %0h expected %0h at %0t", iface.received_data, exp_recv, $time);
      end
    end
  end

  // ---------------- driver ----------------
  // Runs one transaction; cycle c is the cycle after the c-th edge counted
  // from the start-capture edge (c = 0). rst_at >= 0 asserts reset in that cycle.
  task automatic run_txn(input logic [7:0] addr, input logic [7:0] wdata, input int rst_at);
    bit         hit, rd, wack;
    logic [7:0] rbyte;
    hit   = (addr[7:1] == 7'h79);
    rd    = addr[0];
    wack  = (lifo_q.size() < 8);
    rbyte = (lifo_q.size() > 0) ? lifo_q[$] : 8'h00;
    if (hit && rd) exp_q.push_back(rbyte);

    @(negedge clk);
    iface.start = 1'b1;
    iface.Data  = addr;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      iface.start = (c == 10);              // busy-time start must be ignored
      iface.Data  = (c == 19) ? wdata : 8'($urandom);
      if (c == rst_at) begin
        #2;
        rst = 1'b0;
        lifo_q.delete();
        exp_q.delete();
        exp_recv = 8'h00;
        #1;
        check("rst_state", 32'(iface.dbg_state), 32'(IDLE));
        check("rst_ptr", 32'(iface.dbg_ptr), 0);
        check("rst_scl", 32'(iface.dbg_scl), 1);
        @(negedge clk);
        rst = 1'b1;
        iface.start = 1'b0;
        return;
      end
      if (c == 1) check("start_sda", 32'(iface.dbg_sda), 0);
      if (c >= 3 && c <= 17 && (c % 2) == 1)
        check("addr_bit", 32'(iface.dbg_sda), 32'(addr[7 - (c - 3) / 2]));
      if (c == 18) check("ack_scl_low", 32'(iface.dbg_scl), 0);
      if (c == 19) check("addr_ack", 32'(iface.dbg_sda), 32'(!hit));
      if (hit && !rd && c >= 21 && c <= 35 && (c % 2) == 1)
        check("wr_bit", 32'(iface.dbg_sda), 32'(wdata[7 - (c - 21) / 2]));
      if (hit && rd && c >= 21 && c <= 35 && (c % 2) == 1)
        check("rd_bit", 32'(iface.dbg_sda), 32'(rbyte[7 - (c - 21) / 2]));
      if (hit && !rd && c == 37) check("wr_ack", 32'(iface.dbg_sda), 32'(!wack));
    end
    @(posedge clk);   // transaction complete: update the model
    if (hit && !rd && wack) lifo_q.push_back(wdata);
    if (hit && rd) begin
      exp_recv = exp_q.pop_front();
`ifndef LIFO_PEEK_EN
      if (lifo_q.size() > 0) void'(lifo_q.pop_back());
`endif
    end
    @(negedge clk);
    check("end_state", 32'(iface.dbg_state), 32'(IDLE));
    check("end_ptr", 32'(iface.dbg_ptr), 32'(lifo_q.size()));
    check("end_bus", {30'd0, iface.dbg_scl, iface.dbg_sda}, 32'h3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] a;
    rst         = 1'b0;
    iface.start = 1'b0;
    iface.Data  = 8'h00;
    exp_recv    = 8'h00;
    @(negedge clk);
    check("reset_state", 32'(iface.dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_recv", 32'(iface.received_data), 32'h00);
    check("reset_scl_sda", {30'd0, iface.dbg_scl, iface.dbg_sda}, 32'h3);
    check("reset_ptr", 32'(iface.dbg_ptr), 0);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold", 32'(iface.dbg_state), 32'(IDLE));

    // Two writes, three reads (last one on an empty LIFO).
    run_txn(8'hF2, 8'h7A, -1);
    check("lit_ptr1", 32'(iface.dbg_ptr), 1);
    repeat (16) @(negedge clk);
    run_txn(8'hF2, 8'h5A, -1);
    run_txn(8'hF3, 8'h00, -1);
    check("lit_rd1", 32'(iface.received_data), 32'h5A);
    run_txn(8'hF3, 8'h00, -1);
    check("lit_rd2", 32'(iface.received_data), 32'h7A);
    run_txn(8'hF3, 8'h00, -1);
    check("lit_rd3", 32'(iface.received_data), 32'h00);

    // Wrong address leaves LIFO and received_data alone.
    run_txn(8'hF2, 8'h44, -1);
    run_txn(8'hA0, 8'h99, -1);
    check("lit_wrong_ptr", 32'(iface.dbg_ptr), 1);
    check("lit_wrong_recv", 32'(iface.received_data), 32'h00);
    run_txn(8'hF3, 8'h00, -1);
    check("lit_rd44", 32'(iface.received_data), 32'h44);

    // Overflow: nine writes into an 8-deep LIFO.
    for (int i = 0; i < 9; i++) run_txn(8'hF2, 8'(8'h10 + i), -1);
    check("lit_full_ptr", 32'(iface.dbg_ptr), 8);
    run_txn(8'hF3, 8'h00, -1);
    check("lit_rd_ovf", 32'(iface.received_data), 32'h17);

    // Reset in the middle of a write, then read an empty LIFO.
    run_txn(8'hF2, 8'hC3, 25);
    run_txn(8'hF3, 8'h00, -1);
    check("lit_rd_after_rst", 32'(iface.received_data), 32'h00);

    // Random mix of writes, reads and foreign addresses.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = 8'hF2;
        2:       a = 8'hF3;
        default: a = 8'($urandom);
      endcase
      run_txn(a, 8'($urandom), -1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
